// File: rtl/elem_usquare_seq_pkg.sv
// Shared types for the element-wise unsigned fixed-point squarer:
// FSM state encoding and the row-major index walker.
package elem_usquare_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_MUL   = 2'd1;
    localparam state_t ST_STORE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    typedef struct packed {
        int   row;
        int   col;
        logic last;
    } rc_step_t;

    // Row-major step (col fastest), 1-based. 'last' flags the final element;
    // the returned index then wraps to [1][1] so it always stays in range.
    function automatic rc_step_t rc_next(input int row, input int col,
                                         input int rows, input int cols);
        rc_step_t s;
        s.last = (row == rows) && (col == cols);
        if (s.last) begin
            s.row = 1;
            s.col = 1;
        end else if (col == cols) begin
            s.row = row + 1;
            s.col = 1;
        end else begin
            s.row = row;
            s.col = col + 1;
        end
        return s;
    endfunction

endpackage

// File: rtl/elem_usquare_seq_if.sv
// Handshake and matrix bus of elem_usquare_seq: start/a in, busy/done/ovf/f out.
interface elem_usquare_seq_if #(
    parameter int ROWS  = 1,
    parameter int COLS  = 1,
    parameter int WIDTH = 16
);
    logic                                 start;
    logic [ROWS:1][COLS:1][WIDTH-1:0]     a;
    logic                                 busy;
    logic                                 done;
    logic                                 ovf;
    logic [ROWS:1][COLS:1][WIDTH-1:0]     f;

    modport master (output start, a, input busy, done, ovf, f);
    modport slave  (input start, a, output busy, done, ovf, f);
endinterface

// File: rtl/elem_usquare_seq_usquare.sv
// Sequential shift-add squarer: one multiplier bit per cycle, full 2W-bit product.
// The first partial product is taken on the load edge, so p_valid pulses W cycles after load.
module usquare_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WIDTH-1:0]     x,
    output logic [2*WIDTH-1:0]   p,
    output logic                 p_valid
);
    localparam int PW   = 2 * WIDTH;
    localparam int CNTW = $clog2(WIDTH + 1);

    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNTW-1:0]  cnt;
    logic             active;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            acc    <= x[0] ? PW'(x) : '0;
            mcand  <= PW'(x) << 1;
            mplier <= x >> 1;
            cnt    <= CNTW'(WIDTH - 1);
            active <= 1'b1;
        end else if (cnt != '0) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNTW'(1);
        end else begin
            active <= 1'b0;
        end
    end

    assign p       = acc;
    assign p_valid = active && (cnt == '0);

endmodule

// File: rtl/elem_usquare_seq.sv
// Element-wise unsigned fixed-point square f = a^2 through one shared shift-add squarer.
// Define ELEM_USQUARE_ROUND_EN for round-half-up before the fraction shift (default: truncate).
module elem_usquare_seq
    import elem_usquare_seq_pkg::*;
#(
    parameter int ROWS  = 1,
    parameter int COLS  = 1,
    parameter int WIDTH = 16,
    parameter int SCALE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    elem_usquare_seq_if.slave bus
);
    localparam int RW = $clog2(ROWS + 1);
    localparam int CW = $clog2(COLS + 1);
    localparam int PW = 2 * WIDTH;
`ifdef ELEM_USQUARE_ROUND_EN
    localparam logic [PW:0] RND = (PW+1)'((2 ** SCALE) / 2);
`else
    localparam logic [PW:0] RND = '0;
`endif

    typedef logic [ROWS:1][COLS:1][WIDTH-1:0] mat_t;

    state_t           state;
    mat_t             a_q;
    mat_t             f_q;
    logic [RW-1:0]    row;
    logic [CW-1:0]    col;
    logic             ovf_q;

    logic [RW-1:0]    nrow;
    logic [CW-1:0]    ncol;
    logic             nlast;
    logic             load;
    logic [WIDTH-1:0] x;
    logic [PW-1:0]    prod;
    logic             p_valid;
    logic [PW:0]      scaled;
    logic             sat;
    logic [WIDTH-1:0] res;

    usquare_seq #(.WIDTH(WIDTH)) u_sq (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .x       (x),
        .p       (prod),
        .p_valid (p_valid)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rc_step_t nxt;
        nxt   = rc_next(int'(row), int'(col), ROWS, COLS);
        nrow  = RW'(nxt.row);
        ncol  = CW'(nxt.col);
        nlast = nxt.last;
        load  = 1'b0;
        x     = a_q[nrow][ncol];
        case (state)
            ST_IDLE: begin
                load = bus.start;
                x    = bus.a[1][1];
            end
            ST_STORE: load = !nlast;
            default:  load = 1'b0;
        endcase
    end

    // RND is zero in the truncating build and when SCALE=0; the extra bit absorbs the carry.
    assign scaled = ({1'b0, prod} + RND) >> SCALE;
    assign sat    = |scaled[PW:WIDTH];
    assign res    = sat ? '1 : scaled[WIDTH-1:0];

    // NOTE: f is a plain register bank, not a RAM, so it is cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_q   <= '0;
            f_q   <= '0;
            row   <= '0;
            col   <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.a;
                        row   <= RW'(1);
                        col   <= CW'(1);
                        ovf_q <= 1'b0;
                        state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (p_valid)
                        state <= ST_STORE;
                end
                ST_STORE: begin
                    f_q[row][col] <= res;
                    if (sat)
                        ovf_q <= 1'b1;
                    if (nlast) begin
                        state <= ST_DONE;
                    end else begin
                        row   <= nrow;
                        col   <= ncol;
                        state <= ST_MUL;
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = (state != ST_IDLE);
    assign bus.done = (state == ST_DONE);
    assign bus.ovf  = ovf_q;
    assign bus.f    = f_q;

endmodule
